online_operand_serializer: RTL
==============================

ONLINE_OPERAND_SERIALIZER -- requirements
Module: online_operand_serializer

Interface
REQ-001 SHALL have parameters: no_of_digits, default 16, radix-4 digits per operand; radix_bits, default 3, bits per signed digit; delta, default 2, online delay of the downstream multiplier.
REQ-002 SHALL have ports: clk input 1, sole clock, all state on rising edge; reset_n input 1, asynchronous active-low reset.
REQ-003 SHALL have ports: start input 1, request to serialize one operand pair; full_sel_in input 1, 1 = full-length product, 0 = truncated product.
REQ-004 SHALL have ports: a_in input 2*no_of_digits, operand X, two's complement; b_in input 2*no_of_digits, operand Y, two's complement.
REQ-005 SHALL have ports: x output radix_bits, X digit, signed two's complement; y output radix_bits, Y digit, signed two's complement; digit_valid output 1, x/y carry a stream digit.
REQ-006 SHALL have ports: mul_reset output 1, drives the multiplier's extern_reset; full_result_sel output 1, latched full_sel_in; busy output 1, high in every state except IDLE; done output 1, one-cycle completion pulse.

Function
REQ-007 SHALL implement FSM states IDLE, RST, STREAM, FLUSH, DONE.
REQ-008 IDLE: when start=1 at a clock edge, SHALL latch a_in, b_in and full_sel_in, and SHALL go to RST.
REQ-009 start SHALL be ignored in every state other than IDLE, including DONE.
REQ-010 RST: SHALL hold mul_reset=1 and digit_valid=0 for exactly one cycle, then go to STREAM.
REQ-011 STREAM: SHALL last no_of_digits cycles with digit_valid=1, emitting digits MSD-first, then go to FLUSH.
REQ-012 Digit k SHALL be the radix-4 Booth recoding d_k = -2*b[2k+1] + b[2k] + b[2k-1], with b[-1]=0, in the digit set {-2..2}.
REQ-013 Digit k SHALL be emitted in STREAM cycle no_of_digits-1-k, so the first cycle carries k = no_of_digits-1.
REQ-014 The emitted digits of an operand SHALL sum (sum of d_k*4^k) exactly to its two's-complement value for every input, including the most-negative value.
REQ-015 FLUSH: SHALL keep digit_valid=1 with x=y=0.
REQ-016 FLUSH length SHALL be delta+1 cycles when the latched full_sel=0, and no_of_digits+delta+1 cycles when full_sel=1; then go to DONE.
REQ-017 DONE: SHALL assert done=1 and digit_valid=0 for exactly one cycle, then go to IDLE.
REQ-018 The cycle counter SHALL be wide enough for 2*no_of_digits+delta+1 and SHALL clear on every state entry.
REQ-019 Outside STREAM and FLUSH, x and y SHALL be 0.
REQ-020 full_result_sel SHALL hold its latched value from RST through DONE, and SHALL be 0 in IDLE.
REQ-021 All outputs SHALL be registered, with no combinational path from inputs to outputs.

Reset
REQ-022 reset_n=0 SHALL immediately force state IDLE, all outputs to 0 and the counter to 0, including mid-stream.
REQ-023 After reset_n rises, the block SHALL require a new start; an interrupted transfer SHALL NOT resume.

Configuration
REQ-024 With macro ONLINE_SER_ABORT_EN defined, the block SHALL add port abort input 1.
REQ-025 With ONLINE_SER_ABORT_EN defined, abort=1 in RST/STREAM/FLUSH SHALL, on the next edge, clear digit_valid and drive mul_reset=1 for one cycle, then go to IDLE with no done pulse.
REQ-026 With ONLINE_SER_ABORT_EN defined, abort SHALL have priority over all other transitions, and abort in IDLE or DONE SHALL be ignored.
REQ-027 Without ONLINE_SER_ABORT_EN, the abort port SHALL be absent and every transfer SHALL run to DONE.

Verification
REQ-028 a_in=32'h4000_0000, b_in=32'h5555_5555, full_sel_in=0 -> mul_reset for 1 cycle; x=001 then 15x000; y=16x001; then 3 zero digits; done 21 cycles after start.
REQ-029 a_in=32'hFFFF_FFFF, b_in=32'h8000_0000 -> x = 15x000 then 111; y = 110 then 15x000.
REQ-030 full_sel_in=1, any operands -> FLUSH lasts 19 cycles; digit_valid high for 35 consecutive cycles; full_result_sel=1 throughout.
REQ-031 start pulsed in the 5th STREAM cycle and again during DONE -> both ignored; exactly one done pulse; busy low after DONE.
REQ-032 reset_n dropped in the 8th STREAM cycle -> all outputs 0 asynchronously; no done; the next start produces a complete, correct stream.
REQ-033 (ONLINE_SER_ABORT_EN defined) abort=1 in the 3rd FLUSH cycle -> next cycle digit_valid=0, mul_reset=1 for 1 cycle; IDLE with done never asserted.

Source files
------------

// File: rtl/online_operand_serializer.sv
// Serializes two operands as radix-4 Booth digits, MSD first, framed for an online multiplier.
// Define ONLINE_SER_ABORT_EN to add an abort input that cancels a transfer without a done pulse.
module online_operand_serializer #(
   parameter int no_of_digits = 16,
   parameter int radix_bits   = 3,
   parameter int delta        = 2
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      start,
   input  logic                      full_sel_in,
   input  logic [2*no_of_digits-1:0] a_in,
   input  logic [2*no_of_digits-1:0] b_in,
`ifdef ONLINE_SER_ABORT_EN
   input  logic                      abort,
`endif
   output logic [radix_bits-1:0]     x,
   output logic [radix_bits-1:0]     y,
   output logic                      digit_valid,
   output logic                      mul_reset,
   output logic                      full_result_sel,
   output logic                      busy,
   output logic                      done
);
   localparam int W  = 2*no_of_digits;
   localparam int CW = $clog2(2*no_of_digits+delta+2);

`ifdef ONLINE_SER_ABORT_EN
   typedef enum logic [2:0] {IDLE, RST, STREAM, FLUSH, DONE, ABORT} state_t;
`else
   typedef enum logic [2:0] {IDLE, RST, STREAM, FLUSH, DONE} state_t;
`endif

   state_t               r_state;
   state_t               w_next;
   logic [CW-1:0]        r_cnt;
   logic [W:0]           r_sa;
   logic [W:0]           r_sb;
   logic                 r_fsel;
   logic                 w_fsel;
   logic [CW-1:0]        w_flush_last;
   logic signed [2:0]    w_dx;
   logic signed [2:0]    w_dy;

   function automatic logic signed [2:0] booth(input logic [2:0] t);
      case (t)
         3'b001, 3'b010: booth = 3'sd1;
         3'b011:         booth = 3'sd2;
         3'b100:         booth = -3'sd2;
         3'b101, 3'b110: booth = -3'sd1;
         default:        booth = '0;
      endcase
   endfunction

   assign w_fsel       = (r_state == IDLE) ? full_sel_in : r_fsel;
   assign w_flush_last = r_fsel ? CW'(no_of_digits + delta) : CW'(delta);
   assign w_dx         = booth(r_sa[W -: 3]);
   assign w_dy         = booth(r_sb[W -: 3]);

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (start) w_next = RST;
         RST:     w_next = STREAM;
         STREAM:  if (r_cnt == CW'(no_of_digits - 1)) w_next = FLUSH;
         FLUSH:   if (r_cnt == w_flush_last) w_next = DONE;
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
`ifdef ONLINE_SER_ABORT_EN
      if (abort && (r_state == RST || r_state == STREAM || r_state == FLUSH))
         w_next = ABORT;
`endif
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_sa    <= '0;
         r_sb    <= '0;
         r_fsel  <= 1'b0;
      end else begin
         r_state <= w_next;
         r_cnt   <= (w_next != r_state) ? '0 : r_cnt + 1'b1;
         if (r_state == IDLE && start) begin
            r_sa   <= {a_in, 1'b0};
            r_sb   <= {b_in, 1'b0};
            r_fsel <= full_sel_in;
         end else if (w_next == STREAM) begin
            r_sa <= r_sa << 2;
            r_sb <= r_sb << 2;
         end
      end
   end

   // Outputs are registered from the next state, so each reflects the state it is shown in.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         x               <= '0;
         y               <= '0;
         digit_valid     <= 1'b0;
         mul_reset       <= 1'b0;
         full_result_sel <= 1'b0;
         busy            <= 1'b0;
         done            <= 1'b0;
      end else begin
         x               <= (w_next == STREAM) ? radix_bits'(w_dx) : '0;
         y               <= (w_next == STREAM) ? radix_bits'(w_dy) : '0;
         digit_valid     <= (w_next == STREAM) || (w_next == FLUSH);
`ifdef ONLINE_SER_ABORT_EN
         mul_reset       <= (w_next == RST) || (w_next == ABORT);
`else
         mul_reset       <= (w_next == RST);
`endif
         full_result_sel <= (w_next != IDLE) && w_fsel;
         busy            <= (w_next != IDLE);
         done            <= (w_next == DONE);
      end
   end
endmodule
